// File: rtl/multicycle_adder_if.sv
// Handshake and operand/result bundle for multicycle_adder.
// The requester drives through master; the adder connects to slave.
interface multicycle_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic             subtract;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b, carryin, subtract,
        input  busy, done, sum, carryout, overflow, zero
    );

    modport slave (
        input  start, a, b, carryin, subtract,
        output busy, done, sum, carryout, overflow, zero
    );
endinterface

// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with registered sum/carry/overflow/zero results and a start/busy/done handshake.
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_adder_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic             accept, last;
    logic [WIDTH-1:0] op_a, op_b, work_sum, full_sum;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [CHUNK:0]   chunk_res;
    logic             carry_msb;
    logic [WIDTH-1:0] sum_q;
    logic             carryout_q, overflow_q, zero_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (idx == IDXW'(NCHUNK - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands shift right each cycle so the active chunk is always at bit 0;
    // the result shifts in from the top and is fully aligned after NCHUNK steps.
    always_comb begin
        chunk_res = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry};
        full_sum  = (work_sum >> CHUNK)
                  | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));
        carry_msb = chunk_res[CHUNK-1] ^ op_a[CHUNK-1] ^ op_b[CHUNK-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            work_sum   <= '0;
            sum_q      <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (accept) begin
            op_a  <= bus.a;
            op_b  <= bus.subtract ? ~bus.b : bus.b;
            carry <= bus.subtract ^ bus.carryin;
            idx   <= '0;
        end else if (state == RUN) begin
            op_a     <= op_a >> CHUNK;
            op_b     <= op_b >> CHUNK;
            carry    <= chunk_res[CHUNK];
            work_sum <= full_sum;
            idx      <= idx + 1'b1;
            if (last) begin
                sum_q      <= full_sum;
                carryout_q <= chunk_res[CHUNK];
                overflow_q <= carry_msb ^ chunk_res[CHUNK];
                zero_q     <= (full_sum == '0);
            end
        end
    end

    assign bus.sum      = sum_q;
    assign bus.carryout = carryout_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder: an 8-bit/2-bit-chunk instance and a
// 1-bit/1-bit-chunk instance, each checked against an arithmetic reference model.
module tb_multicycle_adder;
    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8_n, rst1_n;

    multicycle_adder_if #(.WIDTH(8)) bus8 ();
    multicycle_adder_if #(.WIDTH(1)) bus1 ();

    multicycle_adder #(.WIDTH(8), .CHUNK(2)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8.slave));
    multicycle_adder #(.WIDTH(1), .CHUNK(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1.slave));

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q8[$];
    exp_t q1[$];

    function automatic exp_t model(int w, logic [7:0] a, logic [7:0] b,
                                   logic cin, logic sub, int due);
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(a) & m;
        longint ub   = sub ? ((~longint'(b)) & m) : (longint'(b) & m);
        longint c0   = ((sub ? !cin : cin) != 0) ? 1 : 0;
        longint tot  = ua + ub + c0;
        longint sa   = (ua >= half) ? ua - 2 * half : ua;
        longint sb   = (ub >= half) ? ub - 2 * half : ub;
        longint st   = sa + sb + c0;
        exp_t   e;
        e.sum  = 8'(tot & m);
        e.cout = ((tot >> w) & 1) != 0;
        e.ovf  = (st > half - 1) || (st < -half);
        e.zero = (tot & m) == 0;
        e.due  = due;
        return e;
    endfunction

    task automatic check(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q8.size() > 0 && q8[0].due < cyc) begin
                check("dut8_done_overdue", cyc, q8[0].due);
                void'(q8.pop_front());
            end
            if (q1.size() > 0 && q1[0].due < cyc) begin
                check("dut1_done_overdue", cyc, q1[0].due);
                void'(q1.pop_front());
            end
            if (bus8.done) begin
                if (q8.size() == 0) check("dut8_unrequested_done", q8.size(), 1);
                else begin
                    e = q8.pop_front();
                    check("dut8_latency",  cyc,           e.due);
                    check("dut8_sum",      bus8.sum,      e.sum);
                    check("dut8_carryout", bus8.carryout, e.cout);
                    check("dut8_overflow", bus8.overflow, e.ovf);
                    check("dut8_zero",     bus8.zero,     e.zero);
                end
            end
            if (bus1.done) begin
                if (q1.size() == 0) check("dut1_unrequested_done", q1.size(), 1);
                else begin
                    e = q1.pop_front();
                    check("dut1_latency",  cyc,           e.due);
                    check("dut1_sum",      bus1.sum,      e.sum[0]);
                    check("dut1_carryout", bus1.carryout, e.cout);
                    check("dut1_overflow", bus1.overflow, e.ovf);
                    check("dut1_zero",     bus1.zero,     e.zero);
                end
            end
        end
    end

    task automatic drive(int w, logic [7:0] a, logic [7:0] b, logic cin, logic sub, logic st);
        if (w == 8) begin
            bus8.a = a; bus8.b = b; bus8.carryin = cin; bus8.subtract = sub; bus8.start = st;
        end else begin
            bus1.a = a[0]; bus1.b = b[0]; bus1.carryin = cin; bus1.subtract = sub; bus1.start = st;
        end
    endtask

    // One isolated operation: start for one cycle, then wait until its DONE cycle.
    task automatic issue(int w, logic [7:0] a, logic [7:0] b, logic cin, logic sub);
        int n = (w == 8) ? 4 : 1;
        @(negedge clk);
        drive(w, a, b, cin, sub, 1'b1);
        if (w == 8) q8.push_back(model(8, a, b, cin, sub, cyc + 1 + n));
        else        q1.push_back(model(1, a, b, cin, sub, cyc + 1 + n));
        @(negedge clk);
        drive(w, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_cleared(string tag);
        check({tag, "_busy"},     bus8.busy,     0);
        check({tag, "_done"},     bus8.done,     0);
        check({tag, "_sum"},      bus8.sum,      0);
        check({tag, "_carryout"}, bus8.carryout, 0);
        check({tag, "_overflow"}, bus8.overflow, 0);
        check({tag, "_zero"},     bus8.zero,     0);
    endtask

    initial begin
        rst8_n = 1'b0;
        rst1_n = 1'b0;
        drive(8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_cleared("reset8");
        check("reset1_busy", bus1.busy, 0);
        check("reset1_sum",  bus1.sum,  0);
        rst8_n = 1'b1;
        rst1_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v = 3'(i);
            issue(1, {7'd0, v[2]}, {7'd0, v[1]}, v[0], 1'b0);
        end
        for (int i = 0; i < 8; i++) issue(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);

        issue(8, 8'hFF, 8'h01, 1'b0, 1'b0);
        issue(8, 8'h7F, 8'h01, 1'b0, 1'b0);
        issue(8, 8'h05, 8'h07, 1'b0, 1'b1);
        issue(8, 8'h80, 8'h01, 1'b0, 1'b1);
        issue(8, 8'h10, 8'h0F, 1'b1, 1'b1);

        // start re-pulsed with different operands during RUN must be ignored
        @(negedge clk);
        drive(8, 8'h21, 8'h43, 1'b0, 1'b0, 1'b1);
        q8.push_back(model(8, 8'h21, 8'h43, 1'b0, 1'b0, cyc + 5));
        @(negedge clk);
        drive(8, 8'hAA, 8'h55, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive(8, 8'h99, 8'h11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // start held through RUN into DONE: second op accepted from DONE
        @(negedge clk);
        drive(8, 8'h3C, 8'h5A, 1'b1, 1'b0, 1'b1);
        q8.push_back(model(8, 8'h3C, 8'h5A, 1'b1, 1'b0, cyc + 5));
        @(negedge clk);
        drive(8, 8'hC3, 8'h0F, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        q8.push_back(model(8, 8'hC3, 8'h0F, 1'b0, 1'b1, cyc + 5));
        @(negedge clk);
        drive(8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        // reset after two of four chunks: op discarded, outputs cleared, no done
        issue(8, 8'h7F, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        drive(8, 8'hE7, 8'h24, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst8_n = 1'b0;
        @(negedge clk);
        check_cleared("midrun_reset");
        rst8_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(8, 8'h12, 8'h34, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            issue(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("dut8_outstanding", q8.size(), 0);
        check("dut1_outstanding", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
